// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}; AN_OFF turns all anodes off.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports: bcd[3:0] in; seg[6:0] out {g..a}, dash for codes 10..15.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with frame-start snapshot.
// Ports: clk, rst (sync high), bcd_in[15:0], dp_in[3:0], blank_lz -> seg[6:0], dp, an[3:0].
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 500
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic [15:0]   bcd_sh;
  logic [3:0]    dp_sh;
  logic          tick;

  logic [3:0]    dig;
  logic [6:0]    dec_seg;
  logic          lz3;
  logic          lz2;
  logic          lz1;
  logic          blank;

  logic [6:0]    seg_nx;
  logic [3:0]    an_nx;
  logic          dp_nx;

  assign tick = (pcnt == PW'(REFRESH_DIV - 1));

  // Shadows reload only at the last tick of digit 3 so a
  // whole frame shows one coherent value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt   <= '0;
      idx    <= 2'd0;
      bcd_sh <= 16'h0000;
      dp_sh  <= 4'b0000;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= idx + 2'd1;
      if (idx == 2'd3) begin
        bcd_sh <= bcd_in;
        dp_sh  <= dp_in;
      end
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  always_comb begin
    dig = bcd_sh[3:0];
    unique case (idx)
      2'd0: dig = bcd_sh[3:0];
      2'd1: dig = bcd_sh[7:4];
      2'd2: dig = bcd_sh[11:8];
      2'd3: dig = bcd_sh[15:12];
    endcase
  end

  // lzN: every digit from 3 down to N is zero.
  assign lz3 = (bcd_sh[15:12] == 4'd0);
  assign lz2 = lz3 && (bcd_sh[11:8] == 4'd0);
  assign lz1 = lz2 && (bcd_sh[7:4] == 4'd0);

  always_comb begin
    blank = 1'b0;
    unique case (idx)
      2'd0: blank = 1'b0;
      2'd1: blank = blank_lz & lz1;
      2'd2: blank = blank_lz & lz2;
      2'd3: blank = blank_lz & lz3;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (dig),
    .seg (dec_seg)
  );

  // Segments keep showing the digit during dead time;
  // only the anodes are held off.
  always_comb begin
    seg_nx = blank ? SEG_BLANK : dec_seg;
    dp_nx  = ~dp_sh[idx];
    an_nx  = ~(4'b0001 << idx);
    if (pcnt < PW'(DEAD_CYC)) begin
      an_nx = AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= AN_OFF;
    end else begin
      seg <= seg_nx;
      dp  <= dp_nx;
      an  <= an_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle scoreboard plus directed slot checks.
// Runs with REFRESH_DIV=4, DEAD_CYC=1.
module tb_seg_scan_driver;

  localparam int DIV  = 4;
  localparam int DEAD = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } pins_t;

  pins_t sb[$];

  seg_scan_driver #(
    .REFRESH_DIV (DIV),
    .DEAD_CYC    (DEAD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Reference model: expected pins one cycle after each edge.
  logic [6:0]  tbl [16];
  int          m_pcnt = 0;
  int          m_idx  = 0;
  logic [15:0] m_bcd  = 16'h0000;
  logic [3:0]  m_dp   = 4'b0000;

  initial begin
    tbl[0] = 7'h40; tbl[1] = 7'h79; tbl[2] = 7'h24;
    tbl[3] = 7'h30; tbl[4] = 7'h19; tbl[5] = 7'h12;
    tbl[6] = 7'h02; tbl[7] = 7'h78; tbl[8] = 7'h00;
    tbl[9] = 7'h10;
    for (int i = 10; i < 16; i++) tbl[i] = 7'h3F;
  end

  always @(posedge clk) begin
    pins_t e;
    logic [3:0] d;
    cyc++;
    if (rst) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
      m_pcnt = 0;
      m_idx  = 0;
      m_bcd  = 16'h0000;
      m_dp   = 4'b0000;
    end else begin
      d = 4'((m_bcd >> (4 * m_idx)) & 16'hF);
      e.seg = tbl[d];
      if (blank_lz && m_idx != 0 &&
          (m_bcd >> (4 * m_idx)) == 16'h0)
        e.seg = 7'h7F;
      e.dp = ~m_dp[m_idx];
      e.an = (m_pcnt < DEAD) ? 4'hF : ~(4'b0001 << m_idx);
      if (m_pcnt == DIV - 1) begin
        m_pcnt = 0;
        if (m_idx == 3) begin
          m_bcd = bcd_in;
          m_dp  = dp_in;
        end
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_pcnt++;
      end
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    pins_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_an",  32'(an),  32'(e.an));
      chk("sb_seg", 32'(seg), 32'(e.seg));
      chk("sb_dp",  32'(dp),  32'(e.dp));
    end
  end

  // Advance to the next negedge where an equals target.
  task automatic wait_an(input logic [3:0] target,
                         input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == target) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk({tag, "_timeout"}, 32'(an), 32'(target));
  endtask

  task automatic slot(input logic [3:0] target,
                      input logic [6:0] s,
                      input logic       p,
                      input string      tag);
    wait_an(target, tag);
    chk({tag, "_seg"}, 32'(seg), 32'(s));
    chk({tag, "_dp"},  32'(dp),  32'(p));
  endtask

  initial begin
    int t0;
    int t1;

    // Reset held three cycles.
    repeat (3) @(negedge clk);
    chk("rst_an",  32'(an),  32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp",  32'(dp),  32'h1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_an0",  32'(an),  32'hF);
    chk("post_seg0", 32'(seg), 32'h40);
    @(negedge clk);
    chk("post_an1",  32'(an),  32'hE);
    chk("post_seg1", 32'(seg), 32'h40);

    // Scan order and decimal point.
    bcd_in = 16'h1234;
    dp_in  = 4'b0100;
    repeat (40) @(negedge clk);
    slot(4'b1110, 7'h19, 1'b1, "scan0");
    slot(4'b1101, 7'h30, 1'b1, "scan1");
    slot(4'b1011, 7'h24, 1'b0, "scan2");
    slot(4'b0111, 7'h79, 1'b1, "scan3");
    wait_an(4'b1111, "fr_off");
    wait_an(4'b1110, "fr_a");
    t0 = cyc;
    wait_an(4'b0111, "fr_b");
    wait_an(4'b1110, "fr_c");
    t1 = cyc;
    chk("frame_len", 32'(t1 - t0), 32'd16);

    // Leading-zero blanking.
    dp_in    = 4'b0000;
    bcd_in   = 16'h0050;
    blank_lz = 1'b1;
    repeat (40) @(negedge clk);
    slot(4'b0111, 7'h7F, 1'b1, "lz3");
    slot(4'b1011, 7'h7F, 1'b1, "lz2");
    slot(4'b1101, 7'h12, 1'b1, "lz1");
    slot(4'b1110, 7'h40, 1'b1, "lz0");
    bcd_in = 16'h0000;
    repeat (40) @(negedge clk);
    slot(4'b1101, 7'h7F, 1'b1, "z1");
    slot(4'b1011, 7'h7F, 1'b1, "z2");
    slot(4'b0111, 7'h7F, 1'b1, "z3");
    slot(4'b1110, 7'h40, 1'b1, "z0");

    // Mid-frame input change is not shown until next frame.
    blank_lz = 1'b0;
    bcd_in   = 16'h1111;
    repeat (40) @(negedge clk);
    wait_an(4'b1101, "snap_sync");
    bcd_in = 16'h9999;
    slot(4'b1011, 7'h79, 1'b1, "snap2");
    slot(4'b0111, 7'h79, 1'b1, "snap3");
    slot(4'b1110, 7'h10, 1'b1, "new0");
    slot(4'b1101, 7'h10, 1'b1, "new1");
    slot(4'b1011, 7'h10, 1'b1, "new2");
    slot(4'b0111, 7'h10, 1'b1, "new3");

    // Invalid codes, then reset mid-frame.
    bcd_in = 16'h00AF;
    repeat (40) @(negedge clk);
    slot(4'b1110, 7'h3F, 1'b1, "inv0");
    slot(4'b1101, 7'h3F, 1'b1, "inv1");
    wait_an(4'b1011, "mid_sync");
    chk("mid_pcnt", 32'(dut.pcnt), 32'd2);
    chk("mid_idx",  32'(dut.idx),  32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_pcnt", 32'(dut.pcnt), 32'd0);
    chk("mrst_idx",  32'(dut.idx),  32'd0);
    chk("mrst_an",   32'(an),       32'hF);
    chk("mrst_seg",  32'(seg),      32'h7F);
    chk("mrst_dp",   32'(dp),       32'h1);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
